// File: rtl/clock_pkg.sv
// Shared types and constants for the clock set/alarm controller.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package clock_pkg;

    localparam int HR_W    = 5;
    localparam int MIN_W   = 6;
    localparam int SEC_W   = 6;
    localparam int HR_MAX  = 23;
    localparam int MIN_MAX = 59;

    typedef enum logic [2:0] {
        RUN      = 3'd0,
        SET_HR   = 3'd1,
        SET_MIN  = 3'd2,
        SET_AHR  = 3'd3,
        SET_AMIN = 3'd4
    } mode_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RING   = 2'd1,
        SNOOZE = 2'd2
    } alarm_state_t;

    // Hours +1 with wrap 23 -> 0.
    function automatic logic [HR_W-1:0] hr_inc(input logic [HR_W-1:0] h);
        return (h == HR_W'(HR_MAX)) ? '0 : h + 1'b1;
    endfunction

    // Minutes +1 with wrap 59 -> 0.
    function automatic logic [MIN_W-1:0] min_inc(input logic [MIN_W-1:0] m);
        return (m == MIN_W'(MIN_MAX)) ? '0 : m + 1'b1;
    endfunction

endpackage

// File: rtl/clock_ctrl_btn_edge.sv
// Rising-edge detector for one externally synchronised button level.
// Latency: press is combinational from level; level_q lags by one cycle.
// Backpressure: none; exactly one press per 0->1 transition however long held.
module btn_edge (
    input  logic clk_1hz,
    input  logic rst,
    input  logic level,
    output logic press
);

    logic level_q;

    // Remember last cycle's level so a held button fires once.
    always_ff @(posedge clk_1hz or posedge rst) begin
        if (rst) level_q <= 1'b0;
        else     level_q <= level;
    end

    assign press = level & ~level_q;

endmodule

// File: rtl/clock_ctrl.sv
// Time/alarm set controller: mode FSM, edit registers, alarm ring/snooze FSM.
// Latency: all outputs registered, reacting on the edge that sees a button press.
// Backpressure: none; hold freezes the counter while the time is being edited.
module clock_ctrl
    import clock_pkg::*;
#(
    parameter int RING_SEC    = 60,
    parameter int SNOOZE_SEC  = 300,
    parameter int MAX_SNOOZE  = 3,
    parameter int ALARM_H_RST = 6,
    parameter int ALARM_M_RST = 0
) (
    input  logic             clk_1hz,
    input  logic             rst,
    input  logic             btn_mode,
    input  logic             btn_inc,
    input  logic             btn_snooze,
    input  logic             alarm_en,
    input  logic [HR_W-1:0]  cur_hours,
    input  logic [MIN_W-1:0] cur_minutes,
    input  logic [SEC_W-1:0] cur_seconds,
    output logic             hold,
    output logic             load,
    output logic [HR_W-1:0]  load_hours,
    output logic [MIN_W-1:0] load_minutes,
    output logic [HR_W-1:0]  alarm_hours,
    output logic [MIN_W-1:0] alarm_minutes,
    output logic [2:0]       mode,
    output logic             buzzer
);

    localparam int RING_W = (RING_SEC > 1) ? $clog2(RING_SEC) : 1;
    localparam int SNZ_W  = (SNOOZE_SEC > 1) ? $clog2(SNOOZE_SEC) : 1;
    localparam int CNT_W  = $clog2(MAX_SNOOZE + 1);

    logic mode_press, inc_press, snooze_press, inc_act;

    btn_edge u_mode_edge   (.clk_1hz(clk_1hz), .rst(rst), .level(btn_mode),   .press(mode_press));
    btn_edge u_inc_edge    (.clk_1hz(clk_1hz), .rst(rst), .level(btn_inc),    .press(inc_press));
    btn_edge u_snooze_edge (.clk_1hz(clk_1hz), .rst(rst), .level(btn_snooze), .press(snooze_press));

    // A mode press swallows a simultaneous inc press.
    assign inc_act = inc_press & ~mode_press;

    mode_t mode_q, mode_d;
    logic  hold_d, load_d;

    // Mode next-state; load pulses only when leaving the time-edit states.
    always_comb begin
        mode_d = mode_q;
        load_d = 1'b0;
        if (mode_press) begin
            case (mode_q)
                RUN:      mode_d = SET_HR;
                SET_HR:   mode_d = SET_MIN;
                SET_MIN: begin
                    mode_d = SET_AHR;
                    load_d = 1'b1;
                end
                SET_AHR:  mode_d = SET_AMIN;
                SET_AMIN: mode_d = RUN;
                default:  mode_d = RUN;
            endcase
        end
        hold_d = (mode_d == SET_HR) || (mode_d == SET_MIN);
    end

    // Mode register with hold/load registered alongside it.
    always_ff @(posedge clk_1hz or posedge rst) begin
        if (rst) begin
            mode_q <= RUN;
            hold   <= 1'b0;
            load   <= 1'b0;
        end else begin
            mode_q <= mode_d;
            hold   <= hold_d;
            load   <= load_d;
        end
    end

    assign mode = mode_q;

    // Edited time and stored alarm; time is snapshotted on entry to SET_HR.
    always_ff @(posedge clk_1hz or posedge rst) begin
        if (rst) begin
            load_hours    <= '0;
            load_minutes  <= '0;
            alarm_hours   <= HR_W'(ALARM_H_RST);
            alarm_minutes <= MIN_W'(ALARM_M_RST);
        end else if (mode_press && (mode_q == RUN)) begin
            load_hours   <= cur_hours;
            load_minutes <= cur_minutes;
        end else if (inc_act) begin
            case (mode_q)
                SET_HR:   load_hours    <= hr_inc(load_hours);
                SET_MIN:  load_minutes  <= min_inc(load_minutes);
                SET_AHR:  alarm_hours   <= hr_inc(alarm_hours);
                SET_AMIN: alarm_minutes <= min_inc(alarm_minutes);
                default:  ;
            endcase
        end
    end

    alarm_state_t     al_q, al_d;
    logic [RING_W-1:0] ring_q, ring_d;
    logic [SNZ_W-1:0]  snz_q, snz_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              abort, trigger;

    assign abort   = ~alarm_en || (mode_q != RUN);
    assign trigger = alarm_en && (mode_q == RUN) && (cur_hours == alarm_hours) &&
                     (cur_minutes == alarm_minutes) && (cur_seconds == '0);

    // Alarm next-state: abort beats snooze, snooze beats ring timeout.
    always_comb begin
        al_d   = al_q;
        ring_d = ring_q;
        snz_d  = snz_q;
        cnt_d  = cnt_q;
        case (al_q)
            IDLE: begin
                if (trigger) begin
                    al_d   = RING;
                    ring_d = '0;
                    cnt_d  = '0;
                end
            end
            RING: begin
                if (abort) begin
                    al_d = IDLE;
                end else if (snooze_press) begin
                    if (cnt_q < CNT_W'(MAX_SNOOZE)) begin
                        al_d  = SNOOZE;
                        snz_d = SNZ_W'(SNOOZE_SEC - 1);
                        cnt_d = cnt_q + 1'b1;
                    end else begin
                        al_d = IDLE;
                    end
                end else if (ring_q == RING_W'(RING_SEC - 1)) begin
                    al_d = IDLE;
                end else begin
                    ring_d = ring_q + 1'b1;
                end
            end
            SNOOZE: begin
                if (abort) begin
                    al_d = IDLE;
                end else if (snz_q == '0) begin
                    al_d   = RING;
                    ring_d = '0;
                end else begin
                    snz_d = snz_q - 1'b1;
                end
            end
            default: al_d = IDLE;
        endcase
    end

    // Alarm state, counters, and buzzer registered from the next state.
    always_ff @(posedge clk_1hz or posedge rst) begin
        if (rst) begin
            al_q   <= IDLE;
            ring_q <= '0;
            snz_q  <= '0;
            cnt_q  <= '0;
            buzzer <= 1'b0;
        end else begin
            al_q   <= al_d;
            ring_q <= ring_d;
            snz_q  <= snz_d;
            cnt_q  <= cnt_d;
            buzzer <= (al_d == RING);
        end
    end

endmodule

// File: tb/tb_clock_ctrl.sv
// Directed bench for clock_ctrl: set-time, set-alarm, ring, snooze, disable, reset.
// Latency: outputs sampled 1 time unit after each rising clk_1hz edge.
// Backpressure: n/a.
module tb_clock_ctrl;

    logic       clk_1hz = 1'b0;
    logic       rst;
    logic       btn_mode, btn_inc, btn_snooze, alarm_en;
    logic [4:0] cur_hours;
    logic [5:0] cur_minutes, cur_seconds;
    logic       hold, load, buzzer;
    logic [4:0] load_hours, alarm_hours;
    logic [5:0] load_minutes, alarm_minutes;
    logic [2:0] mode;

    int n_cmp = 0;
    int n_err = 0;

    clock_ctrl dut (
        .clk_1hz(clk_1hz), .rst(rst),
        .btn_mode(btn_mode), .btn_inc(btn_inc), .btn_snooze(btn_snooze),
        .alarm_en(alarm_en),
        .cur_hours(cur_hours), .cur_minutes(cur_minutes), .cur_seconds(cur_seconds),
        .hold(hold), .load(load),
        .load_hours(load_hours), .load_minutes(load_minutes),
        .alarm_hours(alarm_hours), .alarm_minutes(alarm_minutes),
        .mode(mode), .buzzer(buzzer)
    );

    always #5 clk_1hz = ~clk_1hz;

    task automatic step();
        @(posedge clk_1hz);
        #1;
    endtask

    task automatic press_mode();
        btn_mode = 1'b1; step(); btn_mode = 1'b0; step();
    endtask

    task automatic press_inc();
        btn_inc = 1'b1; step(); btn_inc = 1'b0; step();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        btn_mode = 0; btn_inc = 0; btn_snooze = 0; alarm_en = 0;
        cur_hours = 5'd10; cur_minutes = 6'd20; cur_seconds = 6'd30;
        step(); step();
        n_cmp++; if (mode !== 3'd0) begin n_err++; $display("FAIL reset_mode got %0d exp 0", mode); end
        n_cmp++; if ({hold, load, buzzer} !== 3'b000) begin n_err++; $display("FAIL reset_hold_load_buzzer got %b exp 000", {hold, load, buzzer}); end
        n_cmp++; if ({load_hours, load_minutes} !== 11'd0) begin n_err++; $display("FAIL reset_load_regs got %0d:%0d exp 0:0", load_hours, load_minutes); end
        n_cmp++; if (alarm_hours !== 5'd6 || alarm_minutes !== 6'd0) begin n_err++; $display("FAIL reset_alarm got %0d:%0d exp 6:0", alarm_hours, alarm_minutes); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_set_time();
        btn_mode = 1'b1; step();
        n_cmp++; if (mode !== 3'd1 || hold !== 1'b1) begin n_err++; $display("FAIL enter_set_hr mode=%0d hold=%b exp 1/1", mode, hold); end
        n_cmp++; if (load_hours !== 5'd10 || load_minutes !== 6'd20) begin n_err++; $display("FAIL capture got %0d:%0d exp 10:20", load_hours, load_minutes); end
        btn_mode = 1'b0; step();
        for (int i = 0; i < 13; i++) press_inc();
        n_cmp++; if (load_hours !== 5'd23) begin n_err++; $display("FAIL hr_before_wrap got %0d exp 23", load_hours); end
        press_inc();
        n_cmp++; if (load_hours !== 5'd0) begin n_err++; $display("FAIL hr_wrap got %0d exp 0", load_hours); end
        press_mode();
        n_cmp++; if (mode !== 3'd2 || hold !== 1'b1 || load !== 1'b0) begin n_err++; $display("FAIL enter_set_min mode=%0d hold=%b load=%b exp 2/1/0", mode, hold, load); end
        for (int i = 0; i < 40; i++) press_inc();
        n_cmp++; if (load_minutes !== 6'd0) begin n_err++; $display("FAIL min_wrap got %0d exp 0", load_minutes); end
        btn_mode = 1'b1; step();
        n_cmp++; if (load !== 1'b1 || hold !== 1'b0 || mode !== 3'd3) begin n_err++; $display("FAIL load_pulse load=%b hold=%b mode=%0d exp 1/0/3", load, hold, mode); end
        btn_mode = 1'b0; step();
        n_cmp++; if (load !== 1'b0) begin n_err++; $display("FAIL load_one_cycle got %b exp 0", load); end
        n_cmp++; if (load_hours !== 5'd0 || load_minutes !== 6'd0) begin n_err++; $display("FAIL load_values got %0d:%0d exp 0:0", load_hours, load_minutes); end
    endtask

    task automatic test_set_alarm();
        btn_mode = 1'b1; btn_inc = 1'b1; step();
        n_cmp++; if (mode !== 3'd4 || alarm_hours !== 5'd6) begin n_err++; $display("FAIL mode_beats_inc mode=%0d ahr=%0d exp 4/6", mode, alarm_hours); end
        btn_mode = 1'b0; btn_inc = 1'b0; step();
        for (int i = 0; i < 59; i++) press_inc();
        n_cmp++; if (alarm_minutes !== 6'd59) begin n_err++; $display("FAIL amin_59 got %0d exp 59", alarm_minutes); end
        press_inc();
        n_cmp++; if (alarm_minutes !== 6'd0) begin n_err++; $display("FAIL amin_wrap got %0d exp 0", alarm_minutes); end
        press_mode();
        n_cmp++; if (mode !== 3'd0 || hold !== 1'b0 || load !== 1'b0) begin n_err++; $display("FAIL back_to_run mode=%0d hold=%b load=%b exp 0/0/0", mode, hold, load); end
        press_inc();
        n_cmp++; if (load_hours !== 5'd0 || alarm_hours !== 5'd6 || alarm_minutes !== 6'd0) begin n_err++; $display("FAIL inc_in_run lh=%0d ah=%0d am=%0d exp 0/6/0", load_hours, alarm_hours, alarm_minutes); end
    endtask

    task automatic test_alarm_ring();
        int bad;
        alarm_en = 1'b1;
        cur_hours = 5'd6; cur_minutes = 6'd0; cur_seconds = 6'd0;
        step();
        cur_seconds = 6'd1;
        n_cmp++; if (buzzer !== 1'b1) begin n_err++; $display("FAIL ring_start got %b exp 1", buzzer); end
        bad = 0;
        for (int i = 0; i < 59; i++) begin step(); if (buzzer !== 1'b1) bad++; end
        n_cmp++; if (bad != 0) begin n_err++; $display("FAIL ring_60_cycles low_cycles=%0d exp 0", bad); end
        step();
        n_cmp++; if (buzzer !== 1'b0) begin n_err++; $display("FAIL auto_dismiss got %b exp 0", buzzer); end
        bad = 0;
        for (int i = 2; i < 40; i++) begin cur_seconds = 6'(i); step(); if (buzzer !== 1'b0) bad++; end
        n_cmp++; if (bad != 0) begin n_err++; $display("FAIL no_retrigger high_cycles=%0d exp 0", bad); end
    endtask

    task automatic test_snooze();
        int bad;
        cur_seconds = 6'd0; step(); cur_seconds = 6'd1;
        n_cmp++; if (buzzer !== 1'b1) begin n_err++; $display("FAIL snz_ring_start got %b exp 1", buzzer); end
        for (int k = 1; k <= 3; k++) begin
            btn_snooze = 1'b1; step();
            n_cmp++; if (buzzer !== 1'b0) begin n_err++; $display("FAIL snooze%0d_quiet got %b exp 0", k, buzzer); end
            btn_snooze = 1'b0;
            bad = 0;
            for (int i = 1; i < 300; i++) begin step(); if (buzzer !== 1'b0) bad++; end
            n_cmp++; if (bad != 0) begin n_err++; $display("FAIL snooze%0d_300 high_cycles=%0d exp 0", k, bad); end
            step();
            n_cmp++; if (buzzer !== 1'b1) begin n_err++; $display("FAIL snooze%0d_rering got %b exp 1", k, buzzer); end
        end
        btn_snooze = 1'b1; step();
        btn_snooze = 1'b0;
        n_cmp++; if (buzzer !== 1'b0) begin n_err++; $display("FAIL fourth_dismiss got %b exp 0", buzzer); end
        bad = 0;
        for (int i = 0; i < 400; i++) begin step(); if (buzzer !== 1'b0) bad++; end
        n_cmp++; if (bad != 0) begin n_err++; $display("FAIL stays_dismissed high_cycles=%0d exp 0", bad); end
    endtask

    task automatic test_alarm_disable();
        cur_seconds = 6'd0; step(); cur_seconds = 6'd1;
        n_cmp++; if (buzzer !== 1'b1) begin n_err++; $display("FAIL dis_ring_start got %b exp 1", buzzer); end
        step();
        alarm_en = 1'b0; step();
        n_cmp++; if (buzzer !== 1'b0) begin n_err++; $display("FAIL alarm_en_drop got %b exp 0", buzzer); end
        alarm_en = 1'b1; step(); step();
        n_cmp++; if (buzzer !== 1'b0) begin n_err++; $display("FAIL reenable_same_minute got %b exp 0", buzzer); end
        alarm_en = 1'b0; step();
    endtask

    task automatic test_reset_mid_set();
        press_mode(); press_mode(); press_mode();
        press_inc();
        n_cmp++; if (alarm_hours !== 5'd7) begin n_err++; $display("FAIL ahr_edit got %0d exp 7", alarm_hours); end
        press_mode(); press_mode(); press_mode(); press_mode();
        press_inc();
        n_cmp++; if (mode !== 3'd2 || hold !== 1'b1 || load_minutes !== 6'd1) begin n_err++; $display("FAIL pre_reset mode=%0d hold=%b lm=%0d exp 2/1/1", mode, hold, load_minutes); end
        rst = 1'b1; #1;
        n_cmp++; if (mode !== 3'd0 || hold !== 1'b0 || load !== 1'b0) begin n_err++; $display("FAIL async_reset mode=%0d hold=%b load=%b exp 0/0/0", mode, hold, load); end
        n_cmp++; if (alarm_hours !== 5'd6 || alarm_minutes !== 6'd0 || load_minutes !== 6'd0) begin n_err++; $display("FAIL reset_regs ah=%0d am=%0d lm=%0d exp 6/0/0", alarm_hours, alarm_minutes, load_minutes); end
        step(); rst = 1'b0; step();
        n_cmp++; if (load !== 1'b0 || mode !== 3'd0) begin n_err++; $display("FAIL post_reset load=%b mode=%0d exp 0/0", load, mode); end
    endtask

    initial begin
        test_reset();
        test_set_time();
        test_set_alarm();
        test_alarm_ring();
        test_snooze();
        test_alarm_disable();
        test_reset_mid_set();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/clock_ctrl.md
Name: clock_ctrl

Overview:
Time-set and alarm controller for the 24 h hours/minutes/seconds timekeeping counter. It walks a mode state machine to set the time and the alarm from two buttons. It freezes the counter while the time is being edited, then loads the edited value back with a one-cycle pulse. It compares running time against the stored alarm and sequences ring, snooze and dismiss.

Parameters:
RING_SEC, 60, seconds the buzzer rings before auto-dismiss
SNOOZE_SEC, 300, seconds of silence after a snooze press
MAX_SNOOZE, 3, snoozes allowed per alarm event; the next snooze press dismisses
ALARM_H_RST, 6, alarm hours after reset
ALARM_M_RST, 0, alarm minutes after reset

Ports:
clk_1hz  in  1  1 Hz tick clock
rst  in  1  reset, asynchronous, active-high
btn_mode  in  1  mode button level (synchronised externally)
btn_inc  in  1  increment button level
btn_snooze  in  1  snooze button level
alarm_en  in  1  alarm enable switch level
cur_hours  in  5  counter hours, 0..23
cur_minutes  in  6  counter minutes, 0..59
cur_seconds  in  6  counter seconds, 0..59
hold  out  1  counter must not advance while high
load  out  1  one-cycle pulse; counter takes load_hours/load_minutes and clears seconds
load_hours  out  5  hours value to load
load_minutes  out  6  minutes value to load
alarm_hours  out  5  stored alarm hours
alarm_minutes  out  6  stored alarm minutes
mode  out  3  current mode encoding
buzzer  out  1  alarm sounding

Behaviour:
- Reset is asynchronous and active-high. Reset values:
  - mode=RUN, hold=0, load=0, buzzer=0
  - load_hours=0, load_minutes=0
  - alarm_hours=ALARM_H_RST, alarm_minutes=ALARM_M_RST
  - alarm FSM in IDLE; all counters and edge registers 0
- Button edges: press = level & ~level_q, with level_q registered. Every button acts once per 0->1 transition, regardless of how long it is held.
- Mode FSM (mode encoding): RUN(0) -> SET_HR(1) -> SET_MIN(2) -> SET_AHR(3) -> SET_AMIN(4) -> RUN. Each mode press advances one state.
- RUN->SET_HR: load_hours<=cur_hours and load_minutes<=cur_minutes, captured in the same edge.
- hold=1 exactly while mode is SET_HR or SET_MIN, registered together with mode.
- inc press:
  - SET_HR: load_hours 23 wraps to 0, else +1.
  - SET_MIN: load_minutes 59 wraps to 0, else +1.
  - SET_AHR / SET_AMIN: same rule on alarm_hours / alarm_minutes.
  - RUN: ignored.
- SET_MIN->SET_AHR: load=1 for exactly the next clk_1hz cycle; hold drops in that same cycle. load is never asserted in any other case.
- Mode press and inc press in the same cycle: mode wins, inc is discarded.
- Alarm FSM states IDLE, RING, SNOOZE:
  - IDLE->RING when alarm_en & mode==RUN & cur_hours==alarm_hours & cur_minutes==alarm_minutes & cur_seconds==0. Ring counter and snooze count are cleared on this transition.
  - RING: buzzer=1, registered, high from the cycle after the trigger edge. The ring counter increments each cycle; at RING_SEC-1 the FSM goes to IDLE.
  - RING, snooze press with snooze count < MAX_SNOOZE: go to SNOOZE, snooze counter <= SNOOZE_SEC-1, snooze count +1.
  - RING, snooze press with snooze count == MAX_SNOOZE: go to IDLE (dismiss).
  - SNOOZE: buzzer=0. The snooze counter decrements each cycle; at 0 the FSM goes to RING with the ring counter cleared.
  - From RING or SNOOZE, go to IDLE when alarm_en=0 or mode!=RUN. This takes priority over all other alarm transitions.
  - Retrigger in IDLE happens only on the next equality at seconds==0, so there is no retrigger within the same minute after a dismiss.
- Counter widths: ring counter and snooze counter are each $clog2(max value + 1) bits; snooze count is $clog2(MAX_SNOOZE+1) bits.
- Reset mid-set discards the edited values; load is not pulsed.

Decomposition:
- Shared package clock_pkg holds:
  - mode_t enum (RUN, SET_HR, SET_MIN, SET_AHR, SET_AMIN) and alarm_state_t enum (IDLE, RING, SNOOZE)
  - HR_MAX=23, MIN_MAX=59
  - width constants HR_W=5, MIN_W=6, SEC_W=6
- One natural sub-module: btn_edge, a registered rising-edge detector with async reset, instantiated three times (mode, inc, snooze).

Test Plan:
- Reset, then cur=10:20:xx, mode press -> mode=1, hold=1, load_hours=10, load_minutes=20.
- Continue: 14 inc presses in SET_HR -> load_hours=0 (wrapped after 23); mode; 40 inc presses -> load_minutes=0; mode -> load=1 for exactly one cycle, hold=0, mode=3.
- In SET_AMIN with alarm_minutes=59, inc -> 0; mode and inc pressed together in SET_AHR -> mode=4, alarm_hours unchanged.
- alarm 06:00, alarm_en=1, cur 06:00:00 -> buzzer=1 next cycle; no presses -> buzzer falls after 60 cycles; no retrigger while cur 06:00:xx.
- While ringing, snooze -> buzzer=0 for 300 cycles, then 1. Repeat 3 snoozes; the 4th snooze press -> IDLE, buzzer=0 and it stays 0.
- While ringing, drop alarm_en -> buzzer=0 next cycle. Assert rst mid SET_MIN -> mode=0, hold=0, load=0 immediately, alarm regs = 6:00.
